// File: rtl/sensor_responder.sv
// sensor_responder
// Sensor-side end of the arbiter UART link (8N1, LSB first, idle high).
// Deserializes request bytes from rx_Serial. A read command (byte[7:4]==0)
// whose byte[3:0] equals SENSOR_ID is answered on tx with the echoed request
// byte followed by a captured sensor_data byte. The RX side keeps running
// while a response is being sent.
// Optional build macro: SENSOR_RESP_CHECKSUM_EN appends a third frame
// carrying echo XOR data.
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   rx_Serial    serial request line (asynchronous to clock)
//   sensor_data  live sensor value, captured when a response is started
//   tx           serial response line
//   tx_active    high while response frames are on tx
//   req_valid    1-cycle pulse per well-framed received byte
//   req_byte     last well-framed byte received
//   frame_err    1-cycle pulse when a stop bit samples low
//   busy_drop    1-cycle pulse when an addressed request hits a busy TX
module sensor_responder #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [3:0] SENSOR_ID    = 4'd1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_Serial,
    input  logic [7:0] sensor_data,
    output logic       tx,
    output logic       tx_active,
    output logic       req_valid,
    output logic [7:0] req_byte,
    output logic       frame_err,
    output logic       busy_drop
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0, TX_ECHO = 2'd1, TX_DATA = 2'd2
`ifdef SENSOR_RESP_CHECKSUM_EN
        , TX_SUM = 2'd3
`endif
    } tx_state_t;

    function automatic logic is_addressed(input logic [7:0] b);
        return (b[7:4] == 4'h0) && (b[3:0] == SENSOR_ID);
    endfunction

`ifdef SENSOR_RESP_CHECKSUM_EN
    function automatic logic [7:0] resp_checksum(input logic [7:0] a, input logic [7:0] b);
        return a ^ b;
    endfunction
`endif

    rx_state_t     rx_state_r, rx_state_nxt_s;
    tx_state_t     tx_state_r, tx_state_nxt_s;
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0] rx_cnt_r, tx_cnt_r;
    logic [2:0]    rx_bit_r;
    logic [3:0]    tx_bit_r;
    logic [7:0]    rx_shift_r, echo_r, data_r, req_byte_r, tx_byte_s;
    logic [2:0]    tx_idx_s;
    logic          rx_ok_s, rx_err_s, tx_busy_s, accept_s, tx_frame_end_s, tx_line_s;
    logic          tx_start_r, tx_r, tx_active_r, req_valid_r, frame_err_r, busy_drop_r;

    // TX counts as busy from the start request until it returns to idle.
    assign tx_busy_s = (tx_state_r != TX_IDLE) || tx_start_r;
    assign accept_s  = rx_ok_s && is_addressed(rx_shift_r) && !tx_busy_s;

    // RX state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rx_state_r <= RX_IDLE;
        else        rx_state_r <= rx_state_nxt_s;
    end

    // RX next-state and end-of-frame strobes.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        rx_ok_s        = 1'b0;
        rx_err_s       = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) rx_state_nxt_s = RX_START;
                else                         rx_state_nxt_s = RX_IDLE;
            end
            RX_START: begin
                // A line back high at mid start bit was only a glitch.
                if (rx_cnt_r == CNT_HALF) rx_state_nxt_s = rx_sync_r ? RX_IDLE : RX_DATA;
                else                      rx_state_nxt_s = RX_START;
            end
            RX_DATA: begin
                if ((rx_cnt_r == CNT_LAST) && (rx_bit_r == 3'd7)) rx_state_nxt_s = RX_STOP;
                else                                              rx_state_nxt_s = RX_DATA;
            end
            RX_STOP: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_state_nxt_s = RX_IDLE;
                    rx_ok_s        = rx_sync_r;
                    rx_err_s       = !rx_sync_r;
                end else begin
                    rx_state_nxt_s = RX_STOP;
                end
            end
            default: rx_state_nxt_s = RX_IDLE;
        endcase
    end

    // RX synchronizer, bit timing and data shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_meta_r <= rx_Serial;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            if ((rx_state_r == RX_IDLE) || (rx_state_nxt_s != rx_state_r)) rx_cnt_r <= CNT_ZERO;
            else if (rx_cnt_r == CNT_LAST)                                 rx_cnt_r <= CNT_ZERO;
            else                                                           rx_cnt_r <= rx_cnt_r + CNT_ONE;
            if (rx_state_r == RX_START) begin
                rx_bit_r <= 3'd0;
            end else if ((rx_state_r == RX_DATA) && (rx_cnt_r == CNT_LAST)) begin
                rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                rx_bit_r   <= rx_bit_r + 3'd1;
            end else begin
                rx_bit_r <= rx_bit_r;
            end
        end
    end

    // Request decode: status pulses, response start and byte capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            busy_drop_r <= 1'b0;
            tx_start_r  <= 1'b0;
            req_byte_r  <= 8'h00;
            echo_r      <= 8'h00;
            data_r      <= 8'h00;
        end else begin
            req_valid_r <= rx_ok_s;
            frame_err_r <= rx_err_s;
            busy_drop_r <= rx_ok_s && is_addressed(rx_shift_r) && tx_busy_s;
            tx_start_r  <= accept_s;
            if (rx_ok_s) req_byte_r <= rx_shift_r;
            if (accept_s) begin
                echo_r <= rx_shift_r;
                data_r <= sensor_data;
            end
        end
    end

    // TX state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tx_state_r <= TX_IDLE;
        else        tx_state_r <= tx_state_nxt_s;
    end

    // TX sequencing, byte selection and serial line value.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_byte_s      = 8'hFF;
        tx_line_s      = 1'b1;
        tx_frame_end_s = (tx_cnt_r == CNT_LAST) && (tx_bit_r == 4'd9);
        tx_idx_s       = tx_bit_r[2:0] - 3'd1;  // frame bit 1..8 -> data bit 0..7
        case (tx_state_r)
            TX_IDLE: tx_state_nxt_s = tx_start_r ? TX_ECHO : TX_IDLE;
            TX_ECHO: begin
                tx_byte_s      = echo_r;
                tx_state_nxt_s = tx_frame_end_s ? TX_DATA : TX_ECHO;
            end
            TX_DATA: begin
                tx_byte_s = data_r;
`ifdef SENSOR_RESP_CHECKSUM_EN
                tx_state_nxt_s = tx_frame_end_s ? TX_SUM : TX_DATA;
`else
                tx_state_nxt_s = tx_frame_end_s ? TX_IDLE : TX_DATA;
`endif
            end
`ifdef SENSOR_RESP_CHECKSUM_EN
            TX_SUM: begin
                tx_byte_s      = resp_checksum(echo_r, data_r);
                tx_state_nxt_s = tx_frame_end_s ? TX_IDLE : TX_SUM;
            end
`endif
            default: tx_state_nxt_s = TX_IDLE;
        endcase
        if (tx_state_r == TX_IDLE) tx_line_s = 1'b1;
        else if (tx_bit_r == 4'd0) tx_line_s = 1'b0;
        else if (tx_bit_r == 4'd9) tx_line_s = 1'b1;
        else                       tx_line_s = tx_byte_s[tx_idx_s];
    end

    // TX bit timing and registered line outputs (one cycle behind the FSM).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_cnt_r    <= CNT_ZERO;
            tx_bit_r    <= 4'd0;
            tx_r        <= 1'b1;
            tx_active_r <= 1'b0;
        end else begin
            if ((tx_state_r == TX_IDLE) || (tx_state_nxt_s != tx_state_r)) begin
                tx_cnt_r <= CNT_ZERO;
                tx_bit_r <= 4'd0;
            end else if (tx_cnt_r == CNT_LAST) begin
                tx_cnt_r <= CNT_ZERO;
                tx_bit_r <= tx_bit_r + 4'd1;
            end else begin
                tx_cnt_r <= tx_cnt_r + CNT_ONE;
            end
            tx_r        <= tx_line_s;
            tx_active_r <= (tx_state_r != TX_IDLE);
        end
    end

    assign tx        = tx_r;
    assign tx_active = tx_active_r;
    assign req_valid = req_valid_r;
    assign req_byte  = req_byte_r;
    assign frame_err = frame_err_r;
    assign busy_drop = busy_drop_r;

endmodule

// File: tb/tb_sensor_responder.sv
// Directed self-checking bench for sensor_responder (CLKS_PER_BIT=8, SENSOR_ID=1).
module tb_sensor_responder;
    localparam int CPB = 8;
`ifdef SENSOR_RESP_CHECKSUM_EN
    localparam int NFR = 3;
`else
    localparam int NFR = 2;
`endif
    localparam int RESP = NFR * 10 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] sensor = 8'h00;
    logic       tx, tx_active, req_valid, frame_err, busy_drop;
    logic [7:0] req_byte;

    sensor_responder #(.CLKS_PER_BIT(CPB), .SENSOR_ID(4'd1)) dut (
        .clock(clock), .reset(reset), .rx_Serial(rx), .sensor_data(sensor),
        .tx(tx), .tx_active(tx_active), .req_valid(req_valid), .req_byte(req_byte),
        .frame_err(frame_err), .busy_drop(busy_drop)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int rv_count = 0, rv_cyc = 0, fe_count = 0, bd_count = 0, bd_cyc = 0;
    int act_cycles = 0, act_rise_cyc = 0, tx_low = 0, bad_stop = 0;
    logic act_prev = 1'b0, act_rise_tx = 1'b1;
    logic [7:0] frames_q[$];
    logic mon_busy = 1'b0;
    int mon_ph = 0;
    logic [7:0] mon_byte = 8'h00;
    int n_cmp = 0, n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Passive pulse / activity monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (req_valid) begin rv_count <= rv_count + 1; rv_cyc <= cyc; end
        if (frame_err) fe_count <= fe_count + 1;
        if (busy_drop) begin bd_count <= bd_count + 1; bd_cyc <= cyc; end
        if (tx_active) act_cycles <= act_cycles + 1;
        if (tx_active && !act_prev) begin act_rise_cyc <= cyc; act_rise_tx <= tx; end
        act_prev <= tx_active;
        if (tx !== 1'b1) tx_low <= tx_low + 1;
    end

    // Independent UART frame decoder on tx, sampling mid-bit.
    always @(negedge clock) begin
        if (!reset) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin mon_busy <= 1'b1; mon_ph <= 1; end
        end else begin
            mon_ph <= mon_ph + 1;
            if ((mon_ph % CPB) == CPB / 2 && mon_ph / CPB >= 1 && mon_ph / CPB <= 8)
                mon_byte[mon_ph / CPB - 1] <= tx;
            if (mon_ph == 9 * CPB + CPB / 2) begin
                frames_q.push_back(mon_byte);
                if (tx !== 1'b1) bad_stop <= bad_stop + 1;
                mon_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] qbyte(input int i);
        if (i < frames_q.size()) return frames_q[i];
        else                     return 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic wait_active(input string tag);
        int k = 0;
        while (!tx_active && k < 200) begin tick(1); k++; end
        check(tag, {31'd0, tx_active}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (tx_active && k < 400) begin tick(1); k++; end
        check(tag, {31'd0, tx_active}, 32'd0);
    endtask

    int rv0, fe0, bd0, act0, low0, nq0;

    task automatic snap();
        rv0 = rv_count; fe0 = fe_count; bd0 = bd_count;
        act0 = act_cycles; low0 = tx_low; nq0 = frames_q.size();
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tx_active", {31'd0, tx_active}, 32'd0);
        check("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check("rst_req_byte", {24'd0, req_byte}, 32'h00);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy_drop", {31'd0, busy_drop}, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(CPB);

        // Basic read
        sensor = 8'hA5;
        snap();
        send_byte(8'h01, 1'b1);
        wait_active("t1_start");
        wait_idle("t1_end");
        tick(4);
        check("t1_rv", rv_count - rv0, 32'd1);
        check("t1_req_byte", {24'd0, req_byte}, 32'h01);
        check("t1_nframes", frames_q.size() - nq0, NFR);
        check("t1_echo", {24'd0, qbyte(nq0)}, 32'h01);
        check("t1_data", {24'd0, qbyte(nq0 + 1)}, 32'hA5);
`ifdef SENSOR_RESP_CHECKSUM_EN
        check("t1_sum", {24'd0, qbyte(nq0 + 2)}, 32'hA4);
`endif
        check("t1_active_len", act_cycles - act0, RESP);
        check("t1_latency", act_rise_cyc - rv_cyc, 32'd2);
        check("t1_start_bit", {31'd0, act_rise_tx}, 32'd0);
        check("t1_stops", bad_stop, 32'd0);

        // Wrong address / non-read
        snap();
        send_byte(8'h02, 1'b1);
        tick(CPB);
        send_byte(8'h11, 1'b1);
        tick(3 * CPB);
        check("t2_rv", rv_count - rv0, 32'd2);
        check("t2_req_byte", {24'd0, req_byte}, 32'h11);
        check("t2_active", act_cycles - act0, 32'd0);
        check("t2_tx_low", tx_low - low0, 32'd0);

        // Framing error
        snap();
        send_byte(8'h01, 1'b0);
        tick(3 * CPB);
        check("t3_fe", fe_count - fe0, 32'd1);
        check("t3_rv", rv_count - rv0, 32'd0);
        check("t3_req_byte", {24'd0, req_byte}, 32'h11);
        check("t3_active", act_cycles - act0, 32'd0);
        check("t3_tx_low", tx_low - low0, 32'd0);

        // Busy drop: second request starts at response bit 5
        sensor = 8'h5A;
        snap();
        send_byte(8'h01, 1'b1);
        wait_active("t4_start");
        tick(5 * CPB);
        send_byte(8'h01, 1'b1);
        wait_idle("t4_end");
        tick(3 * CPB);
        check("t4_bd", bd_count - bd0, 32'd1);
        check("t4_bd_with_rv", bd_cyc, rv_cyc);
        check("t4_rv", rv_count - rv0, 32'd2);
        check("t4_active_len", act_cycles - act0, RESP);
        check("t4_nframes", frames_q.size() - nq0, NFR);
        check("t4_echo", {24'd0, qbyte(nq0)}, 32'h01);
        check("t4_data", {24'd0, qbyte(nq0 + 1)}, 32'h5A);
`ifdef SENSOR_RESP_CHECKSUM_EN
        check("t4_sum", {24'd0, qbyte(nq0 + 2)}, 32'h5B);
`endif

        // Data capture held while sensor_data changes
        sensor = 8'h3C;
        snap();
        send_byte(8'h01, 1'b1);
        wait_active("t5_start");
        tick(12 * CPB);
        sensor = 8'hFF;
        wait_idle("t5_end");
        tick(4);
        check("t5_data", {24'd0, qbyte(nq0 + 1)}, 32'h3C);
`ifdef SENSOR_RESP_CHECKSUM_EN
        check("t5_sum", {24'd0, qbyte(nq0 + 2)}, 32'h3D);
`endif
        check("t5_active_len", act_cycles - act0, RESP);

        // Two-cycle glitch on rx
        snap();
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(4 * CPB);
        check("t5g_rv", rv_count - rv0, 32'd0);
        check("t5g_fe", fe_count - fe0, 32'd0);
        check("t5g_bd", bd_count - bd0, 32'd0);
        check("t5g_active", act_cycles - act0, 32'd0);

        // Reset during TX_DATA
        sensor = 8'hC3;
        send_byte(8'h01, 1'b1);
        wait_active("t6_start");
        tick(12 * CPB);
        check("t6_pre_active", {31'd0, tx_active}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_tx", {31'd0, tx}, 32'd1);
        check("t6_async_active", {31'd0, tx_active}, 32'd0);
        tick(3);
        reset = 1'b1;
        tick(4);
        check("t6_req_byte_rst", {24'd0, req_byte}, 32'h00);
        sensor = 8'h77;
        snap();
        send_byte(8'h01, 1'b1);
        wait_active("t6_restart");
        wait_idle("t6_end");
        tick(4);
        check("t6_active_len", act_cycles - act0, RESP);
        check("t6_echo", {24'd0, qbyte(nq0)}, 32'h01);
        check("t6_data", {24'd0, qbyte(nq0 + 1)}, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sensor_responder.md
Name: sensor_responder

Overview:
- Sensor-side end of the arbiter's UART link. It deserializes request bytes arriving on the serial line.
- When a request addresses this sensor, it replies with a framed response of the echoed request plus a sensor data byte on its own tx line.
- One instance per simulated sensor, placed opposite the arbiter in system benches and on-board sensor emulation.
- UART format: 8N1, LSB first, line idles high.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range is 4 or more.
- SENSOR_ID, 4'd1, address this instance answers to (request bits [3:0]).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_Serial  input  1  serial request line from the arbiter; asynchronous to clock.
- sensor_data  input  8  live sensor value; sampled once per accepted request.
- tx  output  1  serial response line to the arbiter.
- tx_active  output  1  high from the first response start bit through the last response stop bit.
- req_valid  output  1  one-cycle pulse when any well-framed byte is received.
- req_byte  output  8  last well-framed byte received; held until the next one.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy_drop  output  1  one-cycle pulse when an addressed request arrives while a response is in progress.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset values: tx=1, tx_active=0, req_valid=0, req_byte=8'h00, frame_err=0, busy_drop=0. Both the RX and TX FSMs go to IDLE.
- Reset mid-frame aborts the frame immediately; tx returns high asynchronously.
- RX synchronization: rx_Serial passes through a 2-FF synchronizer before any use.
- RX FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: a falling edge on the synchronized line moves to RX_START.
  - RX_START: re-sample at CLKS_PER_BIT/2. If the line is high, it was a glitch; return to RX_IDLE with no pulses.
  - RX_DATA: sample 8 bits at mid-bit, every CLKS_PER_BIT cycles, LSB first.
  - RX_STOP: sample the stop bit at mid-bit.
    - Stop bit high: latch req_byte and pulse req_valid.
    - Stop bit low: pulse frame_err and leave req_byte unchanged.
  - The RX FSM always runs, including while TX is active (full duplex).
- Request decode, in the cycle of req_valid:
  - Addressed: byte[7:4]==4'h0 (read command) and byte[3:0]==SENSOR_ID.
  - Addressed and TX idle: capture sensor_data into a data register and start the response.
  - Addressed and TX busy: pulse busy_drop, in the same cycle as req_valid. The request is discarded and the response in progress continues unaffected.
  - Not addressed: ignore silently; no TX activity.
- TX sequencing FSM: TX_IDLE -> TX_ECHO -> TX_DATA [-> TX_SUM] -> TX_IDLE.
  - Each byte-state drives one frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is exactly CLKS_PER_BIT cycles.
  - TX_ECHO sends the accepted request byte; TX_DATA sends the captured sensor_data.
  - Frames are back-to-back: the next start bit begins the cycle after the previous stop bit ends, with no idle gap.
- Latency: the echo start bit appears on tx 2 clock cycles after the req_valid cycle. tx_active rises in the same cycle as that start bit.
- tx_active falls on the cycle after the final stop bit completes. tx stays high in TX_IDLE.
- sensor_data changes during a response do not affect the bytes in flight.
- Bit counters: width is $clog2(CLKS_PER_BIT). Count 0..CLKS_PER_BIT-1, then wrap to 0.

Optional Feature:
- Macro: SENSOR_RESP_CHECKSUM_EN.
- Defined: TX_SUM is inserted after TX_DATA and sends the checksum = echo_byte XOR data_byte. A response is 3 frames (30*CLKS_PER_BIT cycles).
- Undefined: TX_SUM state and logic are absent. A response is 2 frames (20*CLKS_PER_BIT cycles).

Test Plan:
- All scenarios use CLKS_PER_BIT=8, SENSOR_ID=1, with reset deasserted after 5 cycles.
- Basic read: sensor_data=8'hA5; send 8'h01 -> req_valid pulse, req_byte=8'h01. Then tx carries frame 8'h01 followed by frame 8'hA5; tx_active is high for exactly 160 cycles (240 with checksum, third byte 8'hA4). Echo start bit is 2 cycles after req_valid.
- Wrong address / non-read: send 8'h02, then 8'h11 -> req_valid pulses each time; tx stays 1 and tx_active stays 0 throughout.
- Framing error: send 8'h01 with stop bit driven 0 -> frame_err pulses once, req_valid stays 0, req_byte holds its previous value, no response.
- Busy drop: send 8'h01, then send 8'h01 again starting at response bit 5 -> busy_drop pulses with the second req_valid. The first response completes intact and no second response follows.
- Data capture and glitch: sensor_data=8'h3C at request, changed to 8'hFF mid-response -> second byte is 8'h3C. A 2-cycle low glitch on rx_Serial produces no pulses.
- Reset mid-response: assert reset during TX_DATA -> tx=1 and tx_active=0 immediately. After release, a new 8'h01 request is answered normally.
